vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL provide parameter H_TOTAL, default 800, expected clocks per line.
REQ-002 SHALL provide parameter V_TOTAL, default 525, expected lines per frame.
REQ-003 SHALL provide parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-004 SHALL have port clk  input  1  pixel clock (25.175 MHz); the single clock for all logic.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high; the block stays in reset while it is high.
REQ-006 SHALL have port hsync  input  1  horizontal sync, active HI.
REQ-007 SHALL have port vsync  input  1  vertical sync, active HI.
REQ-008 SHALL have port valid  input  1  addressable-video flag, active HI.
REQ-009 SHALL have port pix_x  output  10  column of the current valid pixel.
REQ-010 SHALL have port pix_y  output  10  row of the current valid pixel.
REQ-011 SHALL have port pix_valid  output  1  pix_x/pix_y qualify a pixel.
REQ-012 SHALL have port line_len  output  10  last measured line length in clocks.
REQ-013 SHALL have port frame_lines  output  10  last measured frame length in lines.
REQ-014 SHALL have port locked  output  1  timing matches H_TOTAL/V_TOTAL.
REQ-015 SHALL have port timing_err  output  1  one-cycle pulse on loss of lock.

Function
REQ-016 SHALL register hsync/vsync/valid once; rise = input 1 and registered copy 0.
REQ-017 SHALL keep h_cnt: cleared on hsync rise, else +1, saturating at 1023.
REQ-018 SHALL, on hsync rise with a previous rise seen since reset, load line_len with h_cnt+1 (saturating at 1023) on the same edge.
REQ-019 SHALL keep v_cnt: cleared on vsync rise, else +1 per hsync rise, saturating at 1023.
REQ-020 SHALL, on vsync rise with a previous vsync rise seen, load frame_lines with v_cnt.
REQ-021 SHALL apply the following rule when hsync rise and vsync rise occur in the same cycle: v_cnt becomes 0 (vsync wins) and the line is still measured.
REQ-022 SHALL assert pix_valid one cycle after valid is sampled 1 (latency 1).
REQ-023 SHALL generate pix_x as follows: pix_x = number of valid cycles since the last hsync rise, 0-based; the first valid pixel of a line is 0.
REQ-024 SHALL generate pix_y as follows: pix_y = number of lines containing ≥1 valid cycle since the last vsync rise, 0-based; it advances at the first valid cycle of each new line.
REQ-025 SHALL hold pix_x/pix_y when pix_valid=0, and wrap them modulo 1024.
REQ-026 SHALL implement FSM SEARCH -> MEASURE on the first vsync rise.
REQ-027 SHALL, in MEASURE at each vsync rise, count a good frame if every line_len load in the frame equalled H_TOTAL and v_cnt==V_TOTAL; otherwise it SHALL clear the good count and stay in MEASURE.
REQ-028 SHALL enter LOCKED when the good count reaches LOCK_FRAMES.
REQ-029 SHALL, in LOCKED, go to SEARCH on any line_len load ≠ H_TOTAL, any frame_lines load ≠ V_TOTAL, or h_cnt reaching H_TOTAL+16 without an hsync rise, and pulse timing_err for exactly 1 cycle.
REQ-030 SHALL drive locked=1 iff the state is LOCKED, registered.
REQ-031 SHALL never pulse timing_err outside the LOCKED->SEARCH transition.

Reset
REQ-032 SHALL, while reset=1, drive pix_x=0, pix_y=0, pix_valid=0, line_len=0, frame_lines=0, locked=0, timing_err=0, FSM=SEARCH, all counters, seen-flags and sync registers 0.
REQ-033 SHALL abandon the current measurement on reset mid-frame; the first sync edge after reset does not load line_len/frame_lines.

Verification
REQ-034 SHALL be verified by: reset, then a standard 640x480 stream (800x525) -> line_len=800 after the 2nd hsync, frame_lines=525 after the 2nd vsync, locked=1 after the 3rd vsync rise.
REQ-035 SHALL be verified by: locked, then one line shortened to 799 clocks -> line_len=799, timing_err 1-cycle pulse, locked=0 next cycle, relock after 2 good frames.
REQ-036 SHALL be verified by: valid sampled high for 640 cycles per line -> pix_x 0..639 one cycle later, pix_y 0..479, pix_valid low in blanking.
REQ-037 SHALL be verified by: hsync held low while locked -> timing_err at h_cnt=816, state SEARCH.
REQ-038 SHALL be verified by: hsync and vsync rising in the same cycle -> v_cnt=0, line_len updated.
REQ-039 SHALL be verified by: reset asserted mid-frame while locked -> all outputs 0 next cycle, no timing_err pulse.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a sync/valid video
// stream, measures line and frame lengths, and tracks lock against the
// expected H_TOTAL x V_TOTAL timing.
//
// Stream semantics: hsync, vsync and valid are sampled on every clock.
// There is no backpressure. A pixel is accepted on any cycle where valid is
// sampled high. Its coordinates appear on pix_x/pix_y one cycle later,
// qualified by pix_valid.
//
// fsm_state exposes the lock FSM encoding for observation:
// 0 = SEARCH, 1 = MEASURE, 2 = LOCKED.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       timing_err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [9:0] H_EXP    = 10'(H_TOTAL);
  localparam logic [9:0] V_EXP    = 10'(V_TOTAL);
  localparam logic [9:0] WD_LIMIT = 10'(H_TOTAL + 16);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;

  // Registered copies of the stream inputs (used for edge detection).
  logic hs_q, vs_q, vld_q;

  // Line / frame measurement state.
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_seen_q, h_seen_d;
  logic       v_seen_q, v_seen_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;

  // Pixel coordinate state.
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;
  logic       line_vid_q, line_vid_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;

  // Lock FSM state.
  state_e     state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       line_bad_q, line_bad_d;
  logic       terr_q, terr_d;

  // Combinational helpers.
  logic       hs_rise, vs_rise;
  logic [9:0] line_meas;
  logic       line_load, frame_load;
  logic       line_mismatch, frame_mismatch, frame_good, watchdog;
  logic [7:0] good_inc;
  logic [9:0] x_base, y_base;
  logic       first_vid;

  // Edge detection: a rise is the live input high while its registered copy is low.
  always_comb begin
    hs_rise = hsync & ~hs_q;
    vs_rise = vsync & ~vs_q;
  end

  // Line and frame counters plus the measured-length registers.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_seen_d      = h_seen_q | hs_rise;
    v_seen_d      = v_seen_q | vs_rise;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    // Measured length includes the clock of the closing hsync rise.
    line_meas  = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1;
    line_load  = hs_rise & h_seen_q;
    frame_load = vs_rise & v_seen_q;

    if (hs_rise) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // A coincident vsync rise wins over the hsync increment.
    if (vs_rise) begin
      v_cnt_d = '0;
    end else if (hs_rise && (v_cnt_q != CNT_MAX)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    if (line_load) begin
      line_len_d = line_meas;
    end
    if (frame_load) begin
      frame_lines_d = v_cnt_q;
    end
  end

  // Pixel coordinates: count valid cycles per line and video lines per frame.
  always_comb begin
    x_base    = hs_rise ? 10'd0 : x_cnt_q;
    y_base    = vs_rise ? 10'd0 : y_cnt_q;
    first_vid = hs_rise | vs_rise | ~line_vid_q;

    x_cnt_d    = x_base;
    y_cnt_d    = y_base;
    line_vid_d = (hs_rise | vs_rise) ? 1'b0 : line_vid_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;

    if (valid) begin
      pix_x_d    = x_base;
      x_cnt_d    = x_base + 10'd1;
      line_vid_d = 1'b1;
      // The row advances only on the first valid cycle of each line.
      if (first_vid) begin
        pix_y_d = y_base;
        y_cnt_d = y_base + 10'd1;
      end
    end
  end

  // Lock FSM next-state logic and loss-of-lock pulse.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    terr_d   = 1'b0;
    good_inc = good_q + 8'd1;

    line_mismatch  = line_load & (line_meas != H_EXP);
    frame_mismatch = frame_load & (v_cnt_q != V_EXP);
    // A frame is good when no line in it (including one closed on this
    // very edge) mismatched, and the line count matches.
    frame_good     = ~line_bad_q & ~line_mismatch & (v_cnt_q == V_EXP);
    watchdog       = ~hs_rise & (h_cnt_d == WD_LIMIT);

    // Line-quality flag is scoped to one vsync-to-vsync frame.
    line_bad_d = vs_rise ? 1'b0 : (line_bad_q | line_mismatch);

    case (state_q)
      SEARCH: begin
        good_d = '0;
        if (vs_rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (vs_rise) begin
          if (frame_good) begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (line_mismatch || frame_mismatch || watchdog) begin
          state_d = SEARCH;
          good_d  = '0;
          terr_d  = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      vld_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      line_vid_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      line_bad_q    <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      hs_q          <= hsync;
      vs_q          <= vsync;
      vld_q         <= valid;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_vid_q    <= line_vid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      state_q       <= state_d;
      good_q        <= good_d;
      line_bad_q    <= line_bad_d;
      terr_q        <= terr_d;
    end
  end

  // Output mapping: every output comes straight from a register.
  always_comb begin
    pix_x       = pix_x_q;
    pix_y       = pix_y_q;
    pix_valid   = vld_q;
    line_len    = line_len_q;
    frame_lines = frame_lines_q;
    locked      = (state_q == LOCKED);
    timing_err  = terr_q;
    fsm_state   = state_q;
  end

endmodule
